// File: rtl/snake_core_param.sv
// Snake game engine: direction latch, tick sequencer, body shift register,
// wall/wrap handling, apple growth and self-collision scan.
module snake_core_param #(
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int X_W       = 7,
    parameter int Y_W       = 6,
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 3,
    parameter int WRAP      = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           step,
    input  logic [1:0]                     direction,
    input  logic                           dir_valid,
    input  logic [X_W-1:0]                 apple_x,
    input  logic [Y_W-1:0]                 apple_y,
    input  logic                           apple_valid,
    output logic [X_W-1:0]                 head_x,
    output logic [Y_W-1:0]                 head_y,
    output logic [MAX_LEN*X_W-1:0]         body_x,
    output logic [MAX_LEN*Y_W-1:0]         body_y,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic [$clog2(MAX_LEN+1)-1:0]   score,
    output logic                           ate,
    output logic                           game_over,
    output logic                           victory,
    output logic                           busy,
    output logic                           overrun
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {IDLE, RUN, CALC, CHECK, COMMIT, OVER, WIN} state_t;

    state_t         state;
    logic [X_W-1:0] seg_x [MAX_LEN];
    logic [Y_W-1:0] seg_y [MAX_LEN];
    logic [1:0]     cur_dir;
    logic [1:0]     pend_dir;
    logic [1:0]     ref_dir;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           eat;
    logic           hit;
    logic [IW-1:0]  idx;
    logic [LW-1:0]  len;
    logic [X_W-1:0] calc_x;
    logic [Y_W-1:0] calc_y;
    logic           calc_wall;
    logic           active;

    function automatic logic [X_W-1:0] init_x(int unsigned i);
        int unsigned k;
        k = (i < START_LEN) ? i : START_LEN - 1;
        return X_W'(GRID_W / 2 - k);
    endfunction

    // Next head from the pending direction, which becomes current in CALC.
    always_comb begin
        calc_x    = seg_x[0];
        calc_y    = seg_y[0];
        calc_wall = 1'b0;
        case (pend_dir)
            DIR_UP: begin
                if (seg_y[0] == '0) begin
                    calc_wall = (WRAP == 0);
                    calc_y    = Y_W'(GRID_H - 1);
                end else begin
                    calc_y = seg_y[0] - Y_W'(1);
                end
            end
            DIR_RIGHT: begin
                if (seg_x[0] == X_W'(GRID_W - 1)) begin
                    calc_wall = (WRAP == 0);
                    calc_x    = '0;
                end else begin
                    calc_x = seg_x[0] + X_W'(1);
                end
            end
            DIR_DOWN: begin
                if (seg_y[0] == Y_W'(GRID_H - 1)) begin
                    calc_wall = (WRAP == 0);
                    calc_y    = '0;
                end else begin
                    calc_y = seg_y[0] + Y_W'(1);
                end
            end
            default: begin
                if (seg_x[0] == '0) begin
                    calc_wall = (WRAP == 0);
                    calc_x    = X_W'(GRID_W - 1);
                end else begin
                    calc_x = seg_x[0] - X_W'(1);
                end
            end
        endcase
    end

    // During CALC the pending direction is what the reversal test must guard.
    always_comb begin
        ref_dir = (state == CALC) ? pend_dir : cur_dir;
        active  = (LW'(idx) < len - LW'(1)) || (eat && (LW'(idx) < len));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= Y_W'(GRID_H / 2);
            end
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            len       <= LW'(START_LEN);
            nx        <= '0;
            ny        <= '0;
            eat       <= 1'b0;
            hit       <= 1'b0;
            idx       <= '0;
            ate       <= 1'b0;
            game_over <= 1'b0;
            victory   <= 1'b0;
            overrun   <= 1'b0;
        end else if (start) begin
            state <= RUN;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= Y_W'(GRID_H / 2);
            end
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            len       <= LW'(START_LEN);
            nx        <= '0;
            ny        <= '0;
            eat       <= 1'b0;
            hit       <= 1'b0;
            idx       <= '0;
            ate       <= 1'b0;
            game_over <= 1'b0;
            victory   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            ate <= 1'b0;
            if (dir_valid && (direction != (ref_dir ^ 2'b10)))
                pend_dir <= direction;
            if (step && busy)
                overrun <= 1'b1;
            case (state)
                RUN: begin
                    if (step)
                        state <= CALC;
                end
                CALC: begin
                    cur_dir <= pend_dir;
                    if (calc_wall) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        nx    <= calc_x;
                        ny    <= calc_y;
                        eat   <= apple_valid && (calc_x == apple_x) && (calc_y == apple_y);
                        hit   <= 1'b0;
                        idx   <= '0;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (active && (seg_x[idx] == nx) && (seg_y[idx] == ny))
                        hit <= 1'b1;
                    if (idx == IW'(MAX_LEN - 1))
                        state <= COMMIT;
                    else
                        idx <= idx + IW'(1);
                end
                COMMIT: begin
                    if (hit) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        for (int unsigned i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= nx;
                        seg_y[0] <= ny;
                        if (eat) begin
                            len <= len + LW'(1);
                            ate <= 1'b1;
                        end
                        if (len + LW'(eat) == LW'(MAX_LEN)) begin
                            state   <= WIN;
                            victory <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        body_x = '0;
        body_y = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            body_x[i*X_W +: X_W] = seg_x[i];
            body_y[i*Y_W +: Y_W] = seg_y[i];
        end
        head_x = seg_x[0];
        head_y = seg_y[0];
        length = len;
        score  = len - LW'(START_LEN);
        busy   = (state == CALC) || (state == CHECK) || (state == COMMIT);
    end

endmodule
